// File: rtl/npu_pkg.sv
// Shared NPU types and constants: the tag that tracks a multiply through the
// DSP pipeline, the DSP latency, and the grant statistics width and saturation.
package npu_pkg;

    localparam int DSP_LAT   = 2;
    localparam int STAT_W    = 16;
    localparam int TAG_IDX_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dsp_mult.sv
// Two-stage unsigned multiplier: registers operands when en is high, then
// registers the full-width product. rst_n is an active-high asynchronous reset.
module dsp_mult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] p_q, p_d;

    always_comb begin
        a_d = en ? a : a_q;
        b_d = en ? b : b_q;
        p_d = (2*W)'(a_q) * (2*W)'(b_q);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/dsp_mult_arbiter.sv
// Round-robin arbiter sharing one dsp_mult among NUM_REQ requesters.
// Define DSP_ARB_STATS_EN to add per-requester saturating grant counters.
module dsp_mult_arbiter
    import npu_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BIT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_mask,
    output logic [NUM_REQ-1:0]           resp_valid,
    output logic [2*BIT_WIDTH-1:0]       resp_product,
    output logic                         busy
`ifdef DSP_ARB_STATS_EN
    ,
    input  logic [$clog2(NUM_REQ)-1:0]   stat_sel,
    output logic [STAT_W-1:0]            stat_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     gnt_idx;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic                 xfer;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [BIT_WIDTH-1:0] op_a, op_b;
    tag_t                 tag_q [DSP_LAT];
    tag_t                 tag_d [DSP_LAT];

    assign elig = req_valid & req_mask;

    // Search starts just past the last winner, so the previous grantee goes last.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && elig[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (found && !rst_n) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;
    assign op_a      = req_a[gnt_idx*BIT_WIDTH +: BIT_WIDTH];
    assign op_b      = req_b[gnt_idx*BIT_WIDTH +: BIT_WIDTH];

    always_comb begin
        last_d       = xfer ? gnt_idx : last_q;
        tag_d[0]     = '0;
        tag_d[0].valid = xfer;
        tag_d[0].idx   = TAG_IDX_W'(gnt_idx);
        for (int s = 1; s < DSP_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            last_q <= IDX_W'(NUM_REQ - 1);
            for (int s = 0; s < DSP_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            last_q <= last_d;
            for (int s = 0; s < DSP_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    dsp_mult #(
        .W (BIT_WIDTH)
    ) u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (xfer),
        .a     (op_a),
        .b     (op_b),
        .p     (resp_product)
    );

    always_comb begin
        resp_valid = '0;
        busy       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tag_q[DSP_LAT-1].valid &&
                            (tag_q[DSP_LAT-1].idx == TAG_IDX_W'(i));
        end
        for (int s = 0; s < DSP_LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

`ifdef DSP_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];
    logic [STAT_W-1:0] cnt_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (xfer) begin
            cnt_d[gnt_idx] = sat_inc(cnt_q[gnt_idx]);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Non-power-of-two NUM_REQ leaves unused select codes; they read as zero.
    assign stat_count = (int'(stat_sel) < NUM_REQ) ? cnt_q[stat_sel] : '0;
`endif

endmodule

// File: doc/dsp_mult_arbiter.md
DSP_MULT_ARBITER -- requirements
Module: dsp_mult_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one multiplier, legal range 2..16.
REQ-002 SHALL have parameter BIT_WIDTH, default 8: operand width; the product is 2*BIT_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-high: asserted when 1, despite the name.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-007 SHALL have port req_a  input  NUM_REQ*BIT_WIDTH  packed unsigned operand A; requester i occupies slice i.
REQ-008 SHALL have port req_b  input  NUM_REQ*BIT_WIDTH  packed unsigned operand B, same packing as req_a.
REQ-009 SHALL have port req_mask  input  NUM_REQ  eligibility mask; 1 = requester may be granted.
REQ-010 SHALL have port resp_valid  output  NUM_REQ  one-hot result strobe, one cycle wide, no backpressure.
REQ-011 SHALL have port resp_product  output  2*BIT_WIDTH  product for the requester flagged by resp_valid.
REQ-012 SHALL have port busy  output  1  high while any operation is in flight.

Function
REQ-013 SHALL compute eligibility per cycle as elig = req_valid & req_mask.
REQ-014 SHALL grant at most one requester per cycle, combinationally, by round-robin: search from index last_grant+1 upward, wrapping NUM_REQ-1 to 0.
REQ-015 SHALL drive req_ready = grant; a transfer occurs when req_valid[i] & req_ready[i]. Requesters hold valid and operands until ready.
REQ-016 SHALL update last_grant only on a transfer; with no transfer it holds its value.
REQ-017 SHALL present the granted operands to the multiplier in the transfer cycle; the multiplier registers them, then registers the product (2-cycle latency).
REQ-018 SHALL carry a valid bit plus a requester index through a 2-stage tag pipeline aligned to the multiplier.
REQ-019 SHALL drive resp_valid[idx] high for exactly one cycle, exactly 2 cycles after the transfer, with resp_product = A*B as a full-width unsigned product, no truncation.
REQ-020 SHALL sustain one transfer per cycle: back-to-back grants yield back-to-back responses in grant order.
REQ-021 SHALL drive resp_valid = 0 when no response is due; resp_product is don't-care then.
REQ-022 SHALL drive busy = OR of the tag-pipeline valid bits.
REQ-023 SHALL ignore a requester whose mask bit is 0, even if it is valid; masking a requester does not cancel its in-flight results.
REQ-024 SHALL grant the sole eligible requester every cycle, regardless of the pointer.

Reset
REQ-025 SHALL, on rst_n = 1, immediately clear the tag pipeline, the multiplier registers and the statistics, and set last_grant = NUM_REQ-1 so requester 0 wins first.
REQ-026 SHALL hold req_ready, resp_valid and busy at 0 while reset is asserted; resp_product resets to 0.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no response is produced for them after release.

Configuration
REQ-028 SHALL compile in, when DSP_ARB_STATS_EN is defined, input stat_sel ($clog2(NUM_REQ) bits) and output stat_count (16 bits).
REQ-029 SHALL keep one saturating 16-bit grant counter per requester, incrementing on each transfer and holding at 16'hFFFF.
REQ-030 SHALL drive stat_count combinationally from the counter selected by stat_sel.
REQ-031 SHALL, without DSP_ARB_STATS_EN, have neither the stat ports nor the counters; all other behaviour is identical.

Structure
REQ-032 SHALL take from shared package npu_pkg: the tag struct (valid, index), the DSP latency constant (2) and the stats width (16).
REQ-033 SHALL instantiate the existing dsp_mult block as its single sub-module, driving it with the same clk and rst_n.

Verification
REQ-034 Bench SHALL cover: reset release, then requester 0 valid with A=8'd12, B=8'd10 -> req_ready=4'b0001 in the same cycle; 2 cycles later resp_valid=4'b0001, resp_product=16'd120.
REQ-035 Bench SHALL cover: all 4 requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order, every cycle.
REQ-036 Bench SHALL cover: requester 2 valid, req_mask=4'b1011 -> no grant; unmask -> granted next evaluation; A=B=8'hFF gives resp_product=16'hFE01.
REQ-037 Bench SHALL cover: transfer at cycle t, rst_n asserted at t+1 -> no resp_valid ever appears for it, busy=0; after release requester 0 wins first.
REQ-038 Bench SHALL cover: requesters 1 and 3 valid, last_grant=1 -> 3 granted, then 1 -> pointer wrap verified.
REQ-039 Bench SHALL cover, with DSP_ARB_STATS_EN: 70000 grants to requester 0 -> stat_count (stat_sel=0) = 16'hFFFF; stat_sel=1 reads its own count.
